// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity selectors and line levels
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_ODD   = 1'b1;
    localparam logic PAR_EVEN  = 1'b0;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_piso.sv
// rtl/tx_piso.sv - parallel-load shift-right register with bit counter and last-bit flag
module tx_piso #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data_in,
    output logic             next_lsb,
    output logic             last_bit
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic [BW-1:0]    bit_cnt;

    assign shifted  = shift_reg >> 1;
    // Bit that will sit at the LSB after this edge, so the line register can follow it without lag.
    assign next_lsb = shift ? shifted[0] : shift_reg[0];
    assign last_bit = (bit_cnt == BIT_LAST);

    // Load resets the bit position; each shift moves to the next data bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= data_in;
            bit_cnt   <= '0;
        end else if (shift) begin
            shift_reg <= shifted;
            bit_cnt   <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer (start, data LSB first, optional parity, stop); UART_TX_TWO_STOP_EN selects two stop bits
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int PAR_TYPE     = 1,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA_IN,
    input  logic                  DATA_VALID_IN,
    input  logic                  PAR_EN,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  TX_DONE
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic PAR_SEL = (PAR_TYPE != 0) ? PAR_ODD : PAR_EVEN;

    uart_state_e   state;
    uart_state_e   state_next;
    logic [CW-1:0] cyc_cnt;
    logic          bit_end;
    logic          accept;
    logic          par_en_q;
    logic          par_bit;
    logic          tx_q;
    logic          tx_next;
    logic          done_q;
    logic          done_next;
    logic          piso_shift;
    logic          piso_next_lsb;
    logic          piso_last;
`ifdef UART_TX_TWO_STOP_EN
    logic          stop_second;
`endif

    assign bit_end = (state != IDLE) && (cyc_cnt == CYC_LAST);
    assign accept  = (state == IDLE) && DATA_VALID_IN;

    tx_piso #(
        .WIDTH (DATA_WIDTH)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (piso_shift),
        .data_in  (P_DATA_IN),
        .next_lsb (piso_next_lsb),
        .last_bit (piso_last)
    );

    // Next state, shift strobe, done strobe and the line level for the coming clock.
    always_comb begin
        state_next = state;
        tx_next    = STOP_BIT;
        done_next  = 1'b0;
        piso_shift = 1'b0;
        case (state)
            IDLE:   if (DATA_VALID_IN) state_next = START;
            START:  if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end) begin
                    piso_shift = 1'b1;
                    if (piso_last) state_next = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: if (bit_end) state_next = STOP;
            STOP: begin
                if (bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (stop_second) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
`else
                    state_next = IDLE;
                    done_next  = 1'b1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
        case (state_next)
            START:   tx_next = START_BIT;
            DATA:    tx_next = piso_next_lsb;
            PARITY:  tx_next = par_bit;
            default: tx_next = STOP_BIT;
        endcase
    end

    // State, registered line/done outputs and the per-bit cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx_q    <= STOP_BIT;
            done_q  <= 1'b0;
            cyc_cnt <= '0;
        end else begin
            state   <= state_next;
            tx_q    <= tx_next;
            done_q  <= done_next;
            cyc_cnt <= (state == IDLE || bit_end) ? '0 : cyc_cnt + 1'b1;
        end
    end

    // Parity and parity enable are frozen at accept so later input changes cannot touch the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else if (accept) begin
            par_en_q <= PAR_EN;
            par_bit  <= (^P_DATA_IN) ^ PAR_SEL;
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    // Tracks whether the first of the two stop bits has elapsed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_second <= 1'b0;
        end else if (state == STOP && bit_end) begin
            stop_second <= ~stop_second;
        end
    end
`endif

    assign TX_OUT  = tx_q;
    assign BUSY    = (state != IDLE);
    assign TX_DONE = done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmit end of the UART link; the counterpart of the receive datapath.
- Accepts a DATA_WIDTH-bit parallel word with a valid handshake and drives a line frame, LSB first:
  - start bit (0)
  - DATA_WIDTH data bits
  - optional parity bit
  - stop bit (1)
- Contains its own per-bit timing counter, so each bit is held for CLKS_PER_BIT clocks.
- Sits between the host-side register/FIFO and the TX pin.

Parameters:
- DATA_WIDTH, 4: data bits per frame (>=1).
- PAR_TYPE, 1: 1 = odd parity, 0 = even parity.
- CLKS_PER_BIT, 16: clock cycles per line bit (>=1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- P_DATA_IN  in  DATA_WIDTH  parallel word to send.
- DATA_VALID_IN  in  1  request to send P_DATA_IN.
- PAR_EN  in  1  1 = insert parity bit; sampled at accept.
- TX_OUT  out  1  serial line, idle high.
- BUSY  out  1  high while a frame is in progress.
- TX_DONE  out  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset values (rst low, takes effect immediately, any state): TX_OUT=1, BUSY=0, TX_DONE=0, FSM=IDLE, bit counter=0, cycle counter=0, shift register=0.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when the latched PAR_EN is 0.
- Accept rule: on a clk edge where state=IDLE and DATA_VALID_IN=1:
  - latch P_DATA_IN into the shift register;
  - latch PAR_EN;
  - compute parity = ^P_DATA_IN, XORed with PAR_TYPE (odd: bit makes total ones odd).
- Latency: TX_OUT goes 0 and BUSY goes 1 on the same edge that accepts the word (one cycle after DATA_VALID_IN is presented).
- DATA_VALID_IN while BUSY=1 is ignored; nothing is queued.
- Inputs changing after accept do not affect the frame in progress.
- Bit timing: the cycle counter counts 0..CLKS_PER_BIT-1 in every non-IDLE state. The state advances (or the data bit shifts) when the counter reaches CLKS_PER_BIT-1; the counter then wraps to 0.
- DATA: TX_OUT = shift_reg[0]; shift right on each bit boundary. The bit counter counts 0..DATA_WIDTH-1; leave DATA at the boundary where bit counter = DATA_WIDTH-1.
- STOP: TX_OUT=1. At the end of the stop bit:
  - pulse TX_DONE for 1 cycle;
  - return to IDLE with BUSY=0 on that same edge.
- Back-to-back: a word presented while BUSY=0 in the cycle after TX_DONE is accepted. The minimum line gap is therefore 0 idle bit-times plus one clock.
- Frame length in clocks: (2 + DATA_WIDTH + PAR_EN) * CLKS_PER_BIT.
- TX_OUT is registered and glitch-free; in IDLE it is always 1.
- Reset mid-frame aborts immediately; the line returns high. There is no partial resume.
- CLKS_PER_BIT=1 must work: one clock per bit, with no counter wrap special cases.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: the STOP state lasts 2*CLKS_PER_BIT cycles (two stop bits). TX_DONE pulses at the end of the second stop bit. Frame length grows by CLKS_PER_BIT.
- Undefined: a single stop bit, as above.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef/localparams (IDLE, START, DATA, PARITY, STOP);
  - PAR_ODD=1 and PAR_EVEN=0 constants;
  - line levels START_BIT=0 and STOP_BIT=1.
  The receive side reuses these.
- One sub-module, tx_piso: a parallel-load, shift-right register with a load and a shift enable, plus a bit counter and a last-bit flag. The FSM, cycle counter and parity stay in uart_tx_frame.

Test Plan (DATA_WIDTH=4, CLKS_PER_BIT=4 unless stated):
- Odd parity: PAR_TYPE=1, PAR_EN=1, send 4'b1010.
  - TX_OUT per bit: 0, 0,1,0,1, 1, 1; each bit held 4 clocks.
  - BUSY high for 28 clocks; TX_DONE pulses once at clock 28.
- Even parity: PAR_TYPE=0, PAR_EN=1, send 4'b0111.
  - Bits: 0, 1,1,1,0, 1, 1.
- No parity: PAR_EN=0, send 4'hF.
  - Bits: 0, 1,1,1,1, 1; frame = 24 clocks; no parity slot.
- Busy handling: DATA_VALID_IN held high with 4'h3 then 4'hC.
  - 4'hC is presented during a frame and is ignored.
  - The word present when BUSY drops is accepted back-to-back; start bit begins the cycle after TX_DONE.
- Reset mid-frame: assert rst low during the DATA state of 4'h5.
  - TX_OUT=1, BUSY=0 immediately, without waiting for clk.
  - After release, a new word 4'hA transmits a clean full frame.
- CLKS_PER_BIT=1 with UART_TX_TWO_STOP_EN defined, send 4'h9, PAR_EN=1, odd.
  - Bits: 0, 1,0,0,1, 1, 1,1; 8 clocks total.
